// File: rtl/qea_pkg.sv
// Shared definitions for the QEA host sequencer: default parameter values,
// FSM state encoding, the fixed-point ONE and a command range helper.
package qea_pkg;

  localparam int DEF_PE_NUM                  = 4;
  localparam int DEF_DATA_WIDTH              = 32;
  localparam int DEF_STATE_DATA_WIDTH        = 64;
  localparam int DEF_STATE_ADDR_WIDTH        = 16;
  localparam int DEF_GATE_CONTEXT_DATA_WIDTH = 64;
  localparam int DEF_GATE_CONTEXT_ADDR_WIDTH = 16;
  localparam int DEF_MAX_QBIT_WIDTH          = 6;
  localparam int DEF_NUM_FRAC_BIT            = 30;

  // 1.0 in the engine's fixed-point format (0x40000000)
  localparam logic [DEF_DATA_WIDTH-1:0] ONE = 32'd1 << DEF_NUM_FRAC_BIT;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_CTX   = 3'd1,
    ST_LOAD_STATE = 3'd2,
    ST_START      = 3'd3,
    ST_WAIT       = 3'd4,
    ST_READ       = 3'd5,
    ST_DONE       = 3'd6
  } qea_state_e;

  // A run needs at least one state word and at most 2^STATE_ADDR_WIDTH words
  function automatic logic qbit_num_ok(input logic [DEF_MAX_QBIT_WIDTH-1:0] qbit);
    return (qbit >= 6'd2) && (qbit <= 6'(DEF_STATE_ADDR_WIDTH + 2));
  endfunction

endpackage

// File: rtl/qea_host_seq_if.sv
// Valid/ready stream carrying one full state word per beat.
interface qea_host_seq_if #(
  parameter int W = 256
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qea_res_fifo.sv
// Two-entry result buffer. The head entry drives the stream directly so
// data and valid are register outputs and hold still while stalled.
module qea_res_fifo #(
  parameter int W = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  output logic [1:0]    count,
  qea_host_seq_if.master res
);

  logic         head_v_r;
  logic         tail_v_r;
  logic [W-1:0] head_d_r;
  logic [W-1:0] tail_d_r;
  logic         pop_s;
  logic         load_s;

  assign pop_s  = head_v_r & res.ready;
  assign load_s = ~head_v_r | pop_s;

  // Head refills from tail (or directly from push); tail only catches a push while head is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_v_r <= 1'b0;
      tail_v_r <= 1'b0;
      head_d_r <= '0;
      tail_d_r <= '0;
    end else if (load_s) begin
      if (tail_v_r) begin
        head_v_r <= 1'b1;
        head_d_r <= tail_d_r;
        tail_v_r <= push;
        if (push) tail_d_r <= push_data;
      end else begin
        head_v_r <= push;
        if (push) head_d_r <= push_data;
      end
    end else if (push) begin
      tail_v_r <= 1'b1;
      tail_d_r <= push_data;
    end
  end

  assign count     = {1'b0, head_v_r} + {1'b0, tail_v_r};
  assign res.valid = head_v_r;
  assign res.data  = head_d_r;

endmodule

// File: rtl/qea_host_seq.sv
// Host-side sequencer for the QEA engine: loads gate contexts and the |0>
// initial state, starts the engine, times it, and streams the final state out.
module qea_host_seq import qea_pkg::*; #(
  parameter int PE_NUM                  = DEF_PE_NUM,
  parameter int DATA_WIDTH              = DEF_DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = DEF_STATE_DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = DEF_STATE_ADDR_WIDTH,
  parameter int GATE_CONTEXT_DATA_WIDTH = DEF_GATE_CONTEXT_DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = DEF_GATE_CONTEXT_ADDR_WIDTH,
  parameter int MAX_QBIT_WIDTH          = DEF_MAX_QBIT_WIDTH,
  parameter int NUM_FRAC_BIT            = DEF_NUM_FRAC_BIT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cmd_ins_num,
  input  logic                                 i_ctx_s_valid,
  output logic                                 o_ctx_s_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_s_data,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_qea_ctx_en,
  output logic                                 o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
  output logic                                 o_qea_state_ena,
  output logic                                 o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
  output logic [31:0]                          o_exec_cycles,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_cmd_err
);

  localparam int SW = PE_NUM * STATE_DATA_WIDTH;
  localparam int NW = STATE_ADDR_WIDTH + 1;
  // Amplitude 1.0 on the real part of the top lane of word 0
  localparam logic [SW-1:0] ONE_WORD = {DATA_WIDTH'(ONE), {(SW-DATA_WIDTH){1'b0}}};

  qea_state_e state_r, state_s;

  logic                               cmd_ready_r, ctx_ready_r, start_r, busy_r, done_r, err_r;
  logic [MAX_QBIT_WIDTH-1:0]          qbit_r;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_r, ctx_cnt_r, ctx_addr_r;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_r;
  logic                               ctx_en_r;
  logic [NW-1:0]                      n_r, wr_cnt_r, rd_cnt_r, res_cnt_r;
  logic                               st_ena_r, st_wea_r;
  logic [STATE_ADDR_WIDTH-1:0]        st_addr_r;
  logic [SW-1:0]                      st_din_r;
  logic [31:0]                        exec_r;
  logic                               wait_arm_r, rd_v1_r, rd_v2_r;

  logic       cmd_acc_s, cmd_ok_s, ctx_acc_s, res_acc_s, st_wr_s, rd_issue_s;
  logic [1:0] fifo_cnt_s;
  logic [2:0] occ_s;

  qea_host_seq_if #(.W(SW)) res_if ();

  assign cmd_acc_s  = i_cmd_valid & cmd_ready_r;
  assign cmd_ok_s   = qbit_num_ok(i_cmd_qbit_num);
  assign ctx_acc_s  = i_ctx_s_valid & ctx_ready_r;
  assign res_acc_s  = res_if.valid & res_if.ready;
  assign st_wr_s    = (state_r == ST_LOAD_STATE);
  // Buffered words plus reads still in the RAM pipeline never exceed two
  assign occ_s      = 3'(fifo_cnt_s) + 3'(rd_v1_r) + 3'(rd_v2_r);
  assign rd_issue_s = (state_r == ST_READ) && (rd_cnt_r != n_r) && (occ_s < 3'd2);

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_acc_s && cmd_ok_s) begin
          if (i_cmd_ins_num == '0) state_s = ST_LOAD_STATE;
          else                     state_s = ST_LOAD_CTX;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_CTX: begin
        if (ctx_acc_s && (ctx_cnt_r == ins_r - 16'd1)) state_s = ST_LOAD_STATE;
        else                                           state_s = ST_LOAD_CTX;
      end
      ST_LOAD_STATE: begin
        if (wr_cnt_r == n_r - NW'(1)) state_s = ST_START;
        else                          state_s = ST_LOAD_STATE;
      end
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_arm_r && i_qea_complete) state_s = ST_READ;
        else                              state_s = ST_WAIT;
      end
      ST_READ: begin
        if (res_acc_s && (res_cnt_r == n_r - NW'(1))) state_s = ST_DONE;
        else                                          state_s = ST_READ;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and state-aligned handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      ctx_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      start_r     <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      wait_arm_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      ctx_ready_r <= (state_s == ST_LOAD_CTX);
      busy_r      <= (state_s != ST_IDLE);
      start_r     <= (state_s == ST_START);
      done_r      <= (state_s == ST_DONE);
      err_r       <= cmd_acc_s & ~cmd_ok_s;
      wait_arm_r  <= (state_r == ST_WAIT);
    end
  end

  // Command latch and per-run counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qbit_r    <= '0;
      ins_r     <= '0;
      n_r       <= '0;
      ctx_cnt_r <= '0;
      wr_cnt_r  <= '0;
      rd_cnt_r  <= '0;
      res_cnt_r <= '0;
      exec_r    <= 32'd0;
    end else begin
      if (cmd_acc_s && cmd_ok_s) begin
        qbit_r    <= i_cmd_qbit_num;
        ins_r     <= i_cmd_ins_num;
        n_r       <= NW'(1) << (i_cmd_qbit_num - MAX_QBIT_WIDTH'(2));
        ctx_cnt_r <= '0;
        wr_cnt_r  <= '0;
        rd_cnt_r  <= '0;
        res_cnt_r <= '0;
      end else begin
        if (ctx_acc_s)  ctx_cnt_r <= ctx_cnt_r + 16'd1;
        if (st_wr_s)    wr_cnt_r  <= wr_cnt_r + NW'(1);
        if (rd_issue_s) rd_cnt_r  <= rd_cnt_r + NW'(1);
        if (res_acc_s)  res_cnt_r <= res_cnt_r + NW'(1);
      end
      // Counts WAIT cycles; the cycle that samples completion leaves it frozen
      if (state_s == ST_START)                             exec_r <= 32'd0;
      else if (state_r == ST_WAIT && state_s == ST_WAIT)   exec_r <= exec_r + 32'd1;
    end
  end

  // Context RAM write port, one registered write per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_en_r   <= 1'b0;
      ctx_addr_r <= '0;
      ctx_data_r <= '0;
    end else begin
      ctx_en_r <= ctx_acc_s;
      if (ctx_acc_s) begin
        ctx_addr_r <= ctx_cnt_r;
        ctx_data_r <= i_ctx_s_data;
      end
    end
  end

  // State RAM port: initial-state writes, then result reads and their latency pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_ena_r  <= 1'b0;
      st_wea_r  <= 1'b0;
      st_addr_r <= '0;
      st_din_r  <= '0;
      rd_v1_r   <= 1'b0;
      rd_v2_r   <= 1'b0;
    end else begin
      st_ena_r <= st_wr_s | rd_issue_s;
      st_wea_r <= st_wr_s;
      st_din_r <= (st_wr_s && wr_cnt_r == '0) ? ONE_WORD : '0;
      if (st_wr_s)         st_addr_r <= wr_cnt_r[STATE_ADDR_WIDTH-1:0];
      else if (rd_issue_s) st_addr_r <= rd_cnt_r[STATE_ADDR_WIDTH-1:0];
      rd_v1_r <= rd_issue_s;
      rd_v2_r <= rd_v1_r;
    end
  end

  qea_res_fifo #(.W(SW)) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_v2_r),
    .push_data (i_qea_state_dout),
    .count     (fifo_cnt_s),
    .res       (res_if.master)
  );

  assign res_if.ready      = i_res_ready;
  assign o_res_valid       = res_if.valid;
  assign o_res_data        = res_if.data;
  assign o_cmd_ready       = cmd_ready_r;
  assign o_ctx_s_ready     = ctx_ready_r;
  assign o_qea_start       = start_r;
  assign o_qea_qbit_num    = qbit_r;
  assign o_qea_ctx_en      = ctx_en_r;
  assign o_qea_ctx_wea     = ctx_en_r;
  assign o_qea_ctx_addr    = ctx_addr_r;
  assign o_qea_ctx_data    = ctx_data_r;
  assign o_qea_state_ena   = st_ena_r;
  assign o_qea_state_wea   = st_wea_r;
  assign o_qea_state_addra = st_addr_r;
  assign o_qea_state_dina  = st_din_r;
  assign o_exec_cycles     = exec_r;
  assign o_busy            = busy_r;
  assign o_done            = done_r;
  assign o_cmd_err         = err_r;

endmodule

// File: tb/tb_qea_host_seq.sv
// Randomized bench for qea_host_seq with a behavioural engine/RAM model.
module tb_qea_host_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_cmd_valid, o_cmd_ready;
  logic [5:0]   i_cmd_qbit_num;
  logic [15:0]  i_cmd_ins_num;
  logic         i_ctx_s_valid, o_ctx_s_ready;
  logic [63:0]  i_ctx_s_data;
  logic         o_qea_start;
  logic [5:0]   o_qea_qbit_num;
  logic         o_qea_ctx_en, o_qea_ctx_wea;
  logic [15:0]  o_qea_ctx_addr;
  logic [63:0]  o_qea_ctx_data;
  logic         o_qea_state_ena, o_qea_state_wea;
  logic [15:0]  o_qea_state_addra;
  logic [255:0] o_qea_state_dina;
  logic         i_qea_complete;
  logic [255:0] i_qea_state_dout;
  logic [31:0]  o_exec_cycles;
  logic         o_busy, o_done, o_cmd_err;

  qea_host_seq_if #(.W(256)) res_if ();

  qea_host_seq dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_qbit_num(i_cmd_qbit_num), .i_cmd_ins_num(i_cmd_ins_num),
    .i_ctx_s_valid(i_ctx_s_valid), .o_ctx_s_ready(o_ctx_s_ready), .i_ctx_s_data(i_ctx_s_data),
    .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
    .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
    .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
    .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
    .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout),
    .o_res_valid(res_if.valid), .i_res_ready(res_if.ready), .o_res_data(res_if.data),
    .o_exec_cycles(o_exec_cycles), .o_busy(o_busy), .o_done(o_done), .o_cmd_err(o_cmd_err)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] ONE_WORD = {32'h4000_0000, 224'd0};

  int n_vec = 0;
  int n_err = 0;
  logic [63:0]  ctx_exp [0:511];
  logic [255:0] eng_mem [0:1023];
  int ctx_wr_idx, st_wr_idx, rd_idx, res_idx, done_cnt, start_cnt;
  logic         prev_v, prev_r;
  logic [255:0] prev_d;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // State RAM model with one cycle of read latency
  always @(posedge clk) begin
    if (o_qea_state_ena && !o_qea_state_wea) i_qea_state_dout <= eng_mem[o_qea_state_addra[9:0]];
  end

  // Bus monitor: every RAM access and result beat against the expected sequence
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (o_qea_ctx_en) begin
        check_val("ctx_wea", o_qea_ctx_wea, 1);
        check_val("ctx_addr", o_qea_ctx_addr, ctx_wr_idx);
        check_val("ctx_data", o_qea_ctx_data, ctx_exp[ctx_wr_idx % 512]);
        ctx_wr_idx <= ctx_wr_idx + 1;
      end
      if (o_qea_state_ena && o_qea_state_wea) begin
        check_val("st_addr", o_qea_state_addra, st_wr_idx);
        check_val("st_data", o_qea_state_dina, (st_wr_idx == 0) ? ONE_WORD : 256'd0);
        st_wr_idx <= st_wr_idx + 1;
      end
      if (o_qea_state_ena && !o_qea_state_wea) begin
        check_val("rd_addr", o_qea_state_addra, rd_idx);
        check_val("rd_after_cplt", i_qea_complete, 1);
        rd_idx <= rd_idx + 1;
      end
      if (prev_v && !prev_r) begin
        check_val("stall_valid", res_if.valid, 1);
        check_val("stall_data", res_if.data, prev_d);
      end
      if (res_if.valid && res_if.ready) begin
        check_val("res_data", res_if.data, eng_mem[res_idx % 1024]);
        res_idx <= res_idx + 1;
      end
      if (o_done)      done_cnt  <= done_cnt + 1;
      if (o_qea_start) start_cnt <= start_cnt + 1;
      prev_v <= res_if.valid;
      prev_r <= res_if.ready;
      prev_d <= res_if.data;
    end
  end

  task automatic clear_model(input int ins);
    ctx_wr_idx = 0; st_wr_idx = 0; rd_idx = 0; res_idx = 0; done_cnt = 0; start_cnt = 0;
    for (int i = 0; i < ins; i++) ctx_exp[i] = {$urandom, $urandom};
  endtask

  // Returns #1 after the edge that accepted the command
  task automatic send_cmd(input int qbit, input int ins);
    int b;
    b = 0;
    while (!o_cmd_ready && b < 50) begin @(negedge clk); b++; end
    check_val("cmd_ready", o_cmd_ready, 1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b1; i_cmd_qbit_num = 6'(qbit); i_cmd_ins_num = 16'(ins);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic feed_ctx(input int ins);
    int k, b;
    logic acc;
    k = 0; b = 0;
    while (k < ins && b < 8 * ins + 50) begin
      i_ctx_s_valid = ($urandom_range(0, 3) != 0);
      i_ctx_s_data  = i_ctx_s_valid ? ctx_exp[k] : 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      acc = i_ctx_s_valid && o_ctx_s_ready;
      @(posedge clk); #1;
      if (acc) k++;
      b++;
    end
    if (ins > 0) check_val("ctx_fed", k, ins);
    // Junk beats while not loading contexts must be ignored
    i_ctx_s_valid = 1'b1;
    i_ctx_s_data  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  // d = cycles from the start-pulse cycle to raising complete (d<=0: held high beforehand)
  task automatic do_run(input int qbit, input int ins, input int d, input int pct);
    int n, b, exp_exec;
    n = 1 << (qbit - 2);
    exp_exec = (d <= 1) ? 1 : d - 1;
    clear_model(ins);
    i_qea_complete = (d <= 0);
    i_ctx_s_valid  = 1'b1;
    i_ctx_s_data   = 64'hFEED_FACE_FEED_FACE;
    send_cmd(qbit, ins);
    feed_ctx(ins);
    b = 0;
    do begin @(negedge clk); b++; end while (!o_qea_start && b < n + 100);
    check_val("start_seen", o_qea_start, 1);
    for (int i = 0; i < n; i++) eng_mem[i] = {8{$urandom}};
    @(negedge clk);
    check_val("no_early_rd", o_qea_state_ena, 0);
    if (d >= 1) begin
      repeat (d - 1) @(posedge clk);
      #1;
      i_qea_complete = 1'b1;
    end
    b = 0;
    while (done_cnt == 0 && b < 20 * n + 200) begin
      res_if.ready = ($urandom_range(0, 99) < pct);
      @(posedge clk); #1;
      b++;
    end
    res_if.ready = 1'b0; i_qea_complete = 1'b0; i_ctx_s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("ctx_writes", ctx_wr_idx, ins);
    check_val("st_writes", st_wr_idx, n);
    check_val("rd_count", rd_idx, n);
    check_val("res_beats", res_idx, n);
    check_val("done_once", done_cnt, 1);
    check_val("start_once", start_cnt, 1);
    check_val("exec_cycles", o_exec_cycles, exp_exec);
    check_val("busy_end", o_busy, 0);
    check_val("qbit_out", o_qea_qbit_num, qbit);
  endtask

  task automatic err_cmd(input int qbit);
    clear_model(0);
    send_cmd(qbit, 5);
    @(negedge clk);
    check_val("cmd_err_pulse", o_cmd_err, 1);
    check_val("err_busy", o_busy, 0);
    @(negedge clk);
    check_val("cmd_err_clear", o_cmd_err, 0);
    check_val("err_ready", o_cmd_ready, 1);
    repeat (4) @(negedge clk);
    check_val("err_no_wr", ctx_wr_idx + st_wr_idx, 0);
    check_val("err_busy2", o_busy, 0);
  endtask

  initial begin
    int b;
    rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_qbit_num = 6'd0; i_cmd_ins_num = 16'd0;
    i_ctx_s_valid = 1'b0; i_ctx_s_data = 64'd0; i_qea_complete = 1'b0; res_if.ready = 1'b0;
    clear_model(0);
    repeat (3) @(negedge clk);
    check_val("rst_cmd_ready", o_cmd_ready, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_exec", o_exec_cycles, 0);
    check_val("rst_res_valid", res_if.valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", o_cmd_ready, 1);

    err_cmd(1);
    err_cmd(19);
    do_run(10, 345, 50, 100);
    do_run(2, 0, 5, 100);
    do_run(6, 12, 7, 30);
    do_run(4, 3, 0, 60);

    // Reset in the middle of the initial-state load
    clear_model(2);
    send_cmd(8, 2);
    feed_ctx(2);
    b = 0;
    while (st_wr_idx < 20 && b < 200) begin @(negedge clk); b++; end
    check_val("mid_load_reached", st_wr_idx >= 20, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("mrst_ena", o_qea_state_ena, 0);
    check_val("mrst_busy", o_busy, 0);
    check_val("mrst_ready", o_cmd_ready, 0);
    check_val("mrst_qbit", o_qea_qbit_num, 0);
    check_val("mrst_exec", o_exec_cycles, 0);
    i_ctx_s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mrst_ready_back", o_cmd_ready, 1);
    do_run(5, 4, 10, 50);

    for (int r = 0; r < 3; r++) begin
      do_run($urandom_range(2, 7), $urandom_range(0, 30), $urandom_range(1, 25), $urandom_range(25, 100));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
